key_onehot_capture: RTL and testbench

- Front-end stage that feeds octal_to_binary_encoder.
- Takes 8 raw, asynchronous, active-high key lines and synchronises and debounces them.
- Presents a clean, stable one-hot 8-bit code, plus a one-cycle valid strobe per accepted press.
- Rejects multi-key presses, so the downstream encoder never sees a non-one-hot value while key_held=1.

---
 rtl/key_onehot_capture.sv | 155 +++++++++++++++
 tb/tb_key_onehot_capture.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/key_onehot_capture.sv
// Sync + debounce of 8 key lines into a registered one-hot code; press/release latency DEBOUNCE_CYCLES+3 edges, no backpressure.
// Optional auto-repeat of key_valid while held is enabled by defining KEYCAP_REPEAT_EN.
module key_onehot_capture #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] keys_in,
  output logic [7:0] octal_out,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_err
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("key_onehot_capture: DEBOUNCE_CYCLES must be at least 1");
  end
  if (REPEAT_CYCLES < 2) begin : g_bad_repeat
    $error("key_onehot_capture: REPEAT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    sync1, keys_s;
  logic [7:0]    cand, cand_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [7:0]    octal_nxt;
  logic          valid_nxt, err_nxt;
  logic          cand_onehot;

`ifdef KEYCAP_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rep, rep_nxt;
`endif

  assign cand_onehot = (cand != 8'h00) && ((cand & (cand - 8'h01)) == 8'h00);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1     <= 8'h00;
      keys_s    <= 8'h00;
      state     <= IDLE;
      cand      <= 8'h00;
      cnt       <= '0;
      octal_out <= 8'h00;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      multi_err <= 1'b0;
`ifdef KEYCAP_REPEAT_EN
      rep       <= '0;
`endif
    end else begin
      sync1     <= keys_in;
      keys_s    <= sync1;
      state     <= state_nxt;
      cand      <= cand_nxt;
      cnt       <= cnt_nxt;
      octal_out <= octal_nxt;
      key_valid <= valid_nxt;
      key_held  <= (octal_nxt != 8'h00);
      multi_err <= err_nxt;
`ifdef KEYCAP_REPEAT_EN
      rep       <= rep_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    octal_nxt = octal_out;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
`ifdef KEYCAP_REPEAT_EN
    rep_nxt   = rep;
`endif
    case (state)
      IDLE: begin
        if (keys_s != 8'h00) begin
          state_nxt = DEBOUNCE;
          cand_nxt  = keys_s;
          cnt_nxt   = '0;
        end
      end
      DEBOUNCE: begin
        if (keys_s == 8'h00) begin
          state_nxt = IDLE;
        end else if (keys_s != cand) begin
          cand_nxt = keys_s;
          cnt_nxt  = '0;
        end else if (cnt != CNT_LAST) begin
          cnt_nxt = cnt + 1'b1;
        end else if (cand_onehot) begin
          state_nxt = HELD;
          octal_nxt = cand;
          valid_nxt = 1'b1;
`ifdef KEYCAP_REPEAT_EN
          rep_nxt   = '0;
`endif
        end else begin
          // Multi-key chord: wait for a full release before looking again.
          state_nxt = RELEASE;
          err_nxt   = 1'b1;
          cnt_nxt   = '0;
        end
      end
      HELD: begin
        if (keys_s == 8'h00) begin
          state_nxt = RELEASE;
          cnt_nxt   = '0;
`ifdef KEYCAP_REPEAT_EN
          rep_nxt   = '0;
`endif
        end
`ifdef KEYCAP_REPEAT_EN
        else if (keys_s == octal_out) begin
          if (rep == REP_LAST) begin
            valid_nxt = 1'b1;
            rep_nxt   = '0;
          end else begin
            rep_nxt = rep + 1'b1;
          end
        end
`endif
      end
      RELEASE: begin
        if (keys_s != 8'h00) begin
          cnt_nxt = '0;
        end else if (cnt != CNT_LAST) begin
          cnt_nxt = cnt + 1'b1;
        end else begin
          state_nxt = IDLE;
          octal_nxt = 8'h00;
        end
      end
      default: begin
        state_nxt = IDLE;
        octal_nxt = 8'h00;
      end
    endcase
  end

endmodule

// File: tb/tb_key_onehot_capture.sv
// Directed, table-driven check of key_onehot_capture with default parameters.
module tb_key_onehot_capture;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] keys_in;
  logic [7:0] octal_out;
  logic       key_valid, key_held, multi_err;

  int n_cmp = 0;
  int n_bad = 0;

  key_onehot_capture #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .keys_in   (keys_in),
    .octal_out (octal_out),
    .key_valid (key_valid),
    .key_held  (key_held),
    .multi_err (multi_err)
  );

  always #5 clk = ~clk;

  // Each row: drive keys for n cycles; after every edge expect the listed outputs.
  typedef struct {
    logic [7:0] keys;
    int         n;
    logic [7:0] oct;
    logic       vld;
    logic       held;
    logic       err;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic [7:0] k, input int n, input logic [7:0] o,
                     input logic v, input logic h, input logic e);
    vec_t r;
    r.keys = k; r.n = n; r.oct = o; r.vld = v; r.held = h; r.err = e;
    tbl.push_back(r);
  endtask

  task automatic check(input string name, input int idx, input logic [10:0] want);
    logic [10:0] got;
    got = {octal_out, key_valid, key_held, multi_err};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s #%0d: got oct=%h vld=%b held=%b err=%b, want oct=%h vld=%b held=%b err=%b",
               name, idx, got[10:3], got[2], got[1], got[0],
               want[10:3], want[2], want[1], want[0]);
    end
  endtask

  task automatic step(input logic [7:0] k, input string name, input int idx,
                      input logic [10:0] want);
    keys_in = k;
    @(posedge clk);
    #1;
    check(name, idx, want);
  endtask

  initial begin
    int st;
`ifdef KEYCAP_REPEAT_EN
    int vcount;
    logic [7:0] oct_seen;
`endif
    rst_n   = 1'b0;
    keys_in = 8'h00;
    for (int i = 0; i < 3; i++) step(8'h00, "reset", i, 11'h000);
    rst_n = 1'b1;

    // Clean press of 08 for 20 cycles, then clean release
    row(8'h08, 6, 8'h00, 0, 0, 0);  row(8'h08, 1, 8'h08, 1, 1, 0);
    row(8'h08, 13, 8'h08, 0, 1, 0); row(8'h00, 6, 8'h08, 0, 1, 0);
    row(8'h00, 1, 8'h00, 0, 0, 0);  row(8'h00, 3, 8'h00, 0, 0, 0);
    // Bounce during DEBOUNCE on 40
    row(8'h40, 2, 8'h00, 0, 0, 0);  row(8'h00, 1, 8'h00, 0, 0, 0);
    row(8'h40, 6, 8'h00, 0, 0, 0);  row(8'h40, 1, 8'h40, 1, 1, 0);
    row(8'h40, 5, 8'h40, 0, 1, 0);  row(8'h00, 6, 8'h40, 0, 1, 0);
    row(8'h00, 1, 8'h00, 0, 0, 0);  row(8'h00, 3, 8'h00, 0, 0, 0);
    // Multi-key chord 11, then single key 01
    row(8'h11, 6, 8'h00, 0, 0, 0);  row(8'h11, 1, 8'h00, 0, 0, 1);
    row(8'h11, 3, 8'h00, 0, 0, 0);  row(8'h00, 6, 8'h00, 0, 0, 0);
    row(8'h01, 6, 8'h00, 0, 0, 0);  row(8'h01, 1, 8'h01, 1, 1, 0);
    row(8'h01, 3, 8'h01, 0, 1, 0);  row(8'h00, 6, 8'h01, 0, 1, 0);
    row(8'h00, 1, 8'h00, 0, 0, 0);  row(8'h00, 3, 8'h00, 0, 0, 0);
    // Rollover: 02 accepted, then 06 ignored
    row(8'h02, 6, 8'h00, 0, 0, 0);  row(8'h02, 1, 8'h02, 1, 1, 0);
    row(8'h02, 2, 8'h02, 0, 1, 0);  row(8'h06, 5, 8'h02, 0, 1, 0);
    row(8'h00, 6, 8'h02, 0, 1, 0);  row(8'h00, 1, 8'h00, 0, 0, 0);
    row(8'h00, 3, 8'h00, 0, 0, 0);
    // Bounce during RELEASE on 10
    row(8'h10, 6, 8'h00, 0, 0, 0);  row(8'h10, 1, 8'h10, 1, 1, 0);
    row(8'h10, 3, 8'h10, 0, 1, 0);  row(8'h00, 2, 8'h10, 0, 1, 0);
    row(8'h10, 1, 8'h10, 0, 1, 0);  row(8'h00, 5, 8'h10, 0, 1, 0);
    row(8'h00, 1, 8'h00, 0, 0, 0);  row(8'h00, 3, 8'h00, 0, 0, 0);
    // Short glitch (3 cycles) is rejected
    row(8'h04, 3, 8'h00, 0, 0, 0);  row(8'h00, 5, 8'h00, 0, 0, 0);
    // Candidate change mid-debounce restarts the count
    row(8'h01, 2, 8'h00, 0, 0, 0);  row(8'h02, 6, 8'h00, 0, 0, 0);
    row(8'h02, 1, 8'h02, 1, 1, 0);  row(8'h02, 1, 8'h02, 0, 1, 0);
    row(8'h00, 6, 8'h02, 0, 1, 0);  row(8'h00, 1, 8'h00, 0, 0, 0);
    row(8'h00, 2, 8'h00, 0, 0, 0);

    st = 0;
    foreach (tbl[r]) begin
      for (int k = 0; k < tbl[r].n; k++) begin
        step(tbl[r].keys, "tbl", st,
             {tbl[r].oct, tbl[r].vld, tbl[r].held, tbl[r].err});
        st++;
      end
    end

    // Reset while a key is held, then fresh re-detection
    for (int i = 1; i <= 6; i++) step(8'h80, "rst_press", i, 11'h000);
    step(8'h80, "rst_press", 7, {8'h80, 3'b110});
    for (int i = 8; i <= 10; i++) step(8'h80, "rst_press", i, {8'h80, 3'b010});
    rst_n = 1'b0;
    step(8'h80, "rst_low", 0, 11'h000);
    step(8'h80, "rst_low", 1, 11'h000);
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) step(8'h80, "rst_redet", i, 11'h000);
    step(8'h80, "rst_redet", 7, {8'h80, 3'b110});
    step(8'h80, "rst_redet", 8, {8'h80, 3'b010});
    for (int i = 1; i <= 6; i++) step(8'h00, "rst_rel", i, {8'h80, 3'b010});
    step(8'h00, "rst_rel", 7, 11'h000);

`ifdef KEYCAP_REPEAT_EN
    for (int i = 0; i < 4; i++) step(8'h00, "rep_idle", i, 11'h000);
    vcount = 0;
    for (int e = 1; e <= 60; e++) begin
      keys_in = 8'h20;
      @(posedge clk);
      #1;
      oct_seen = (e >= 7) ? 8'h20 : 8'h00;
      check("rep", e, {oct_seen, (e == 7 || e == 23 || e == 39 || e == 55),
                       (e >= 7), 1'b0});
      if (key_valid) vcount++;
    end
    n_cmp++;
    if (vcount != 4) begin
      n_bad++;
      $display("FAIL rep_count: got %0d pulses, want 4", vcount);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
